// File: rtl/fetch_decode_stage.sv
// Fetch and field-split stage: sequences the PC, fetches words over a
// request/ready port and presents opcode/register/immediate fields downstream.
module fetch_decode_stage #(
  parameter int unsigned IMM_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [5:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [IMM_W-1:0] out_imm,
  output logic             out_u
);

  localparam int unsigned AddrW  = 32;
  localparam int unsigned InstrW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [AddrW-1:0]  pc;
  logic [AddrW-1:0]  pcNext;
  logic [InstrW-1:0] instr;
  logic [InstrW-1:0] instrNext;

  // State, PC and instruction register; reset wins over redirect and handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      instr <= instrNext;
    end
  end

  // Next-state, capture and handshake decode
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    instrNext = instr;
    imem_req  = 1'b0;
    out_valid = 1'b0;

    case (state)
      IDLE: stateNext = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instrNext = imem_data;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pcNext    = pc + AddrW'(PC_STEP);
          stateNext = FETCH;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Redirect discards any same-cycle response and masks the held bundle
    if (redirect_valid) begin
      out_valid = 1'b0;
      instrNext = instr;
      pcNext    = redirect_pc;
      stateNext = FETCH;
    end
  end

  assign imem_addr  = pc;
  assign out_pc     = pc;
  assign out_opcode = instr[31:26];
  assign out_rd     = instr[25:21];
  assign out_rs1    = instr[20:16];
  assign out_imm    = instr[IMM_W-1:0];
  assign out_u      = instr[31];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outPc;
  logic [5:0]  outOpcode;
  logic [4:0]  outRd;
  logic [4:0]  outRs1;
  logic [15:0] outImm;
  logic        outU;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  fetch_decode_stage #(.IMM_W(16), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_ready(imemReady), .imem_data(imemData),
    .redirect_valid(redirectValid), .redirect_pc(redirectPc),
    .out_valid(outValid), .out_ready(outReady), .out_pc(outPc),
    .out_opcode(outOpcode), .out_rd(outRd), .out_rs1(outRs1),
    .out_imm(outImm), .out_u(outU)
  );

  // Advance one rising edge and settle 1ns after the next falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imemReady = 1'b1; imemData = 32'hFFFF_FFFF;
    redirectValid = 1'b0; redirectPc = 32'h0; outReady = 1'b1;
    @(negedge clk);
    cyc(); cyc();
    nChecks++; if (imemReq !== 1'b0) begin nFails++; $display("FAIL reset_req: got %b want 0", imemReq); end
    nChecks++; if (outValid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b want 0", outValid); end
    nChecks++; if (outPc !== 32'h0) begin nFails++; $display("FAIL reset_pc: got %h want 0", outPc); end
    nChecks++; if ({outOpcode, outRd, outRs1, outImm, outU} !== 33'h0) begin nFails++; $display("FAIL reset_fields: got %h want 0", {outOpcode, outRd, outRs1, outImm, outU}); end
    rst = 1'b0;
    #1;
    nChecks++; if (imemReq !== 1'b0) begin nFails++; $display("FAIL idle_req: got %b want 0", imemReq); end
    cyc();
  endtask

  // Plan 1: addresses 0,4,8 with one instruction every two cycles
  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      imemReady = 1'b1; imemData = 32'h0C22_0000 | 32'(i); outReady = 1'b1;
      #1;
      nChecks++; if (imemReq !== 1'b1 || imemAddr !== 32'(4 * i)) begin nFails++; $display("FAIL basic_fetch%0d: got req=%b addr=%h want req=1 addr=%h", i, imemReq, imemAddr, 32'(4 * i)); end
      nChecks++; if (outValid !== 1'b0) begin nFails++; $display("FAIL basic_novalid%0d: got %b want 0", i, outValid); end
      cyc();
      nChecks++; if (outValid !== 1'b1 || outPc !== 32'(4 * i) || outImm !== 16'(i) || imemReq !== 1'b0) begin nFails++; $display("FAIL basic_hold%0d: got v=%b pc=%h imm=%h req=%b want v=1 pc=%h imm=%h req=0", i, outValid, outPc, outImm, imemReq, 32'(4 * i), 16'(i)); end
      cyc();
    end
  endtask

  // Plan 2: field split of two words, opcode MSB set and clear
  task automatic test_fields();
    imemReady = 1'b1; imemData = 32'h8C22_FFF0; outReady = 1'b0;
    cyc();
    nChecks++; if (outOpcode !== 6'h23 || outRd !== 5'd1 || outRs1 !== 5'd2) begin nFails++; $display("FAIL fields_regs: got op=%h rd=%0d rs1=%0d want op=23 rd=1 rs1=2", outOpcode, outRd, outRs1); end
    nChecks++; if (outImm !== 16'hFFF0 || outU !== 1'b1) begin nFails++; $display("FAIL fields_imm_u1: got imm=%h u=%b want imm=fff0 u=1", outImm, outU); end
    outReady = 1'b1;
    cyc();
    imemData = 32'h0C22_0007; outReady = 1'b0;
    cyc();
    nChecks++; if (outImm !== 16'h0007 || outU !== 1'b0 || outPc !== 32'h10) begin nFails++; $display("FAIL fields_imm_u0: got imm=%h u=%b pc=%h want imm=0007 u=0 pc=10", outImm, outU, outPc); end
  endtask

  // Plan 3: downstream stall for five cycles in HOLD
  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      imemReady = i[0]; imemData = 32'hDEAD_0000 | 32'(i); outReady = 1'b0;
      #1;
      nChecks++; if (outValid !== 1'b1 || outPc !== 32'h10 || outImm !== 16'h0007 || outU !== 1'b0 || imemReq !== 1'b0 || imemAddr !== 32'h10) begin nFails++; $display("FAIL stall%0d: got v=%b pc=%h imm=%h u=%b req=%b addr=%h want v=1 pc=10 imm=0007 u=0 req=0 addr=10", i, outValid, outPc, outImm, outU, imemReq, imemAddr); end
      cyc();
    end
    outReady = 1'b1; imemReady = 1'b0;
    #1;
    nChecks++; if (outValid !== 1'b1) begin nFails++; $display("FAIL stall_release: got %b want 1", outValid); end
    cyc();
    nChecks++; if (imemReq !== 1'b1 || imemAddr !== 32'h14 || outImm !== 16'h0007) begin nFails++; $display("FAIL stall_next: got req=%b addr=%h imm=%h want req=1 addr=14 imm=0007", imemReq, imemAddr, outImm); end
  endtask

  // Plan 4: memory not ready for three cycles
  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      imemReady = 1'b0; imemData = 32'hBAD0_0000 | 32'(i);
      #1;
      nChecks++; if (imemReq !== 1'b1 || imemAddr !== 32'h14 || outValid !== 1'b0) begin nFails++; $display("FAIL memwait%0d: got req=%b addr=%h v=%b want req=1 addr=14 v=0", i, imemReq, imemAddr, outValid); end
      cyc();
    end
    imemReady = 1'b1; imemData = 32'h0C22_1234; outReady = 1'b1;
    cyc();
    nChecks++; if (outValid !== 1'b1 || outImm !== 16'h1234 || outPc !== 32'h14) begin nFails++; $display("FAIL memwait_capture: got v=%b imm=%h pc=%h want v=1 imm=1234 pc=14", outValid, outImm, outPc); end
    cyc();
  endtask

  // Plan 5: redirect against a fetch response and against a held bundle
  task automatic test_redirect();
    imemReady = 1'b1; imemData = 32'h0C22_BEEF; redirectValid = 1'b1; redirectPc = 32'h100;
    cyc();
    redirectValid = 1'b0;
    #1;
    nChecks++; if (imemReq !== 1'b1 || imemAddr !== 32'h100 || outValid !== 1'b0 || outImm !== 16'h1234) begin nFails++; $display("FAIL redir_fetch: got req=%b addr=%h v=%b imm=%h want req=1 addr=100 v=0 imm=1234", imemReq, imemAddr, outValid, outImm); end
    imemData = 32'h0C22_0042; outReady = 1'b1;
    cyc();
    redirectValid = 1'b1; redirectPc = 32'h100;
    #1;
    nChecks++; if (outValid !== 1'b0) begin nFails++; $display("FAIL redir_hold_valid: got %b want 0", outValid); end
    cyc();
    redirectValid = 1'b0; imemReady = 1'b0;
    #1;
    nChecks++; if (imemReq !== 1'b1 || imemAddr !== 32'h100 || outImm !== 16'h0042) begin nFails++; $display("FAIL redir_hold_next: got req=%b addr=%h imm=%h want req=1 addr=100 imm=0042", imemReq, imemAddr, outImm); end
  endtask

  // Plan 6a: PC wraps from the top of the address space
  task automatic test_wrap();
    redirectValid = 1'b1; redirectPc = 32'hFFFF_FFFC; imemReady = 1'b0;
    cyc();
    redirectValid = 1'b0; imemReady = 1'b1; imemData = 32'h0C22_0001; outReady = 1'b1;
    cyc();
    nChecks++; if (outValid !== 1'b1 || outPc !== 32'hFFFF_FFFC) begin nFails++; $display("FAIL wrap_hold: got v=%b pc=%h want v=1 pc=fffffffc", outValid, outPc); end
    cyc();
    nChecks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin nFails++; $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=0", imemReq, imemAddr); end
  endtask

  // Plan 6b: reset with a redirect while holding a bundle
  task automatic test_reset_hold();
    imemReady = 1'b1; imemData = 32'h8C22_5555; outReady = 1'b0;
    cyc();
    nChecks++; if (outValid !== 1'b1 || outImm !== 16'h5555) begin nFails++; $display("FAIL rsthold_pre: got v=%b imm=%h want v=1 imm=5555", outValid, outImm); end
    rst = 1'b1; redirectValid = 1'b1; redirectPc = 32'h300; outReady = 1'b1;
    cyc();
    rst = 1'b0; redirectValid = 1'b0;
    #1;
    nChecks++; if (outValid !== 1'b0 || imemReq !== 1'b0 || outPc !== 32'h0 || outImm !== 16'h0 || outU !== 1'b0) begin nFails++; $display("FAIL rsthold_idle: got v=%b req=%b pc=%h imm=%h u=%b want v=0 req=0 pc=0 imm=0 u=0", outValid, imemReq, outPc, outImm, outU); end
    cyc();
    nChecks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin nFails++; $display("FAIL rsthold_fetch: got req=%b addr=%h want req=1 addr=0", imemReq, imemAddr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fields();
    test_stall();
    test_mem_wait();
    test_redirect();
    test_wrap();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
